// File: rtl/multi_sample_fetcher_if.sv
// Memory read-port bundle between the sample fetcher (master) and the DDR3 read bridge (slave).
interface multi_sample_fetcher_if #(
  parameter int unsigned ADDR_W = 29,
  parameter int unsigned DATA_W = 64
) ();
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;
  logic              mem_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;

  modport master (
    input  mem_data, mem_ack, mem_wait,
    output mem_addr, mem_read_en
  );

  modport slave (
    output mem_data, mem_ack, mem_wait,
    input  mem_addr, mem_read_en
  );
endinterface

// File: rtl/multi_sample_fetcher.sv
// Round-robin DDR3 chunk fetcher serving CHANNELS sample streams with one read outstanding.
// Stream replay (loop port) is built only when SAMPLE_FETCHER_LOOP_EN is defined.
module multi_sample_fetcher #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CHUNKS_LOG2 = 6,
  parameter int unsigned ADDR_W      = 29,
  parameter int unsigned DATA_W      = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  multi_sample_fetcher_if.master     mem,
  output logic [CHANNELS*DATA_W-1:0] chunk,
  output logic [CHANNELS-1:0]        chunk_valid,
  input  logic [CHANNELS-1:0]        chunk_ack,
  input  logic [CHANNELS*ADDR_W-1:0] base,
  input  logic [CHANNELS-1:0]        base_valid,
`ifdef SAMPLE_FETCHER_LOOP_EN
  input  logic [CHANNELS-1:0]        loop,
`endif
  output logic [CHANNELS-1:0]        base_ack
);

  localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_READ_WAIT
  } state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_gnt;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [ADDR_W-1:0]      r_addr       [CHANNELS];
  logic [CHUNKS_LOG2-1:0] r_chunk_addr [CHANNELS];
  logic [CHANNELS-1:0]    r_addr_valid;

  logic [CHANNELS-1:0]    w_eligible;
  logic                   w_found;
  logic [PTR_W-1:0]       w_pick;
  logic [PTR_W-1:0]       w_idx;
  logic [ADDR_W-1:0]      w_req_addr;
  logic [PTR_W-1:0]       w_rr_next;
  logic                   w_last;
  logic                   w_replay;

  assign base_ack   = base_valid & ~r_addr_valid & {CHANNELS{~reset}};
  assign w_eligible = r_addr_valid & ~chunk_valid;

  // First eligible channel at or after the round-robin pointer, searching cyclically.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_idx = PTR_W'((32'(r_rr_ptr) + k) % CHANNELS);
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_req_addr = r_addr[w_pick] + ADDR_W'(r_chunk_addr[w_pick]);
  assign w_rr_next  = PTR_W'((32'(w_pick) + 32'd1) % CHANNELS);
  assign w_last     = &r_chunk_addr[r_gnt];

`ifdef SAMPLE_FETCHER_LOOP_EN
  assign w_replay = loop[r_gnt];
`else
  assign w_replay = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_gnt           <= '0;
      r_rr_ptr        <= '0;
      r_addr_valid    <= '0;
      chunk           <= '0;
      chunk_valid     <= '0;
      mem.mem_addr    <= '0;
      mem.mem_read_en <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_addr[i]       <= '0;
        r_chunk_addr[i] <= '0;
      end
    end else begin
      // Base acceptance and consumer handshake; a granted channel never sees either.
      for (int i = 0; i < CHANNELS; i++) begin
        if (base_ack[i]) begin
          r_addr[i]       <= base[i*ADDR_W +: ADDR_W];
          r_addr_valid[i] <= 1'b1;
          r_chunk_addr[i] <= '0;
        end
        if (chunk_ack[i] && chunk_valid[i]) begin
          chunk_valid[i] <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt           <= w_pick;
            r_rr_ptr        <= w_rr_next;
            mem.mem_addr    <= w_req_addr;
            mem.mem_read_en <= 1'b1;
            r_state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (!mem.mem_wait) begin
            mem.mem_read_en <= 1'b0;
            r_state         <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (mem.mem_ack) begin
            chunk[32'(r_gnt)*DATA_W +: DATA_W] <= mem.mem_data;
            chunk_valid[r_gnt]                 <= 1'b1;
            r_chunk_addr[r_gnt]                <= r_chunk_addr[r_gnt] + CHUNKS_LOG2'(1);
            if (w_last && !w_replay) begin
              r_addr_valid[r_gnt] <= 1'b0;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_sample_fetcher.sv
// Scoreboard bench for multi_sample_fetcher: expected requests/chunks queued by stimulus, checked by monitors.
module tb_multi_sample_fetcher;

  localparam int NCH = 4;
  localparam int AW  = 29;
  localparam int DW  = 64;

  typedef struct {
    int          ch;
    logic [63:0] data;
  } chk_t;

  logic              clk;
  logic              rst;
  logic [NCH*DW-1:0] chunk;
  logic [NCH-1:0]    chunk_valid;
  logic [NCH-1:0]    chunk_ack;
  logic [NCH*AW-1:0] base;
  logic [NCH-1:0]    base_valid;
  logic [NCH-1:0]    base_ack;
`ifdef SAMPLE_FETCHER_LOOP_EN
  logic [NCH-1:0]    loop;
`endif

  multi_sample_fetcher_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  multi_sample_fetcher #(
    .CHANNELS(NCH), .CHUNKS_LOG2(6), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .mem         (mem_if),
    .chunk       (chunk),
    .chunk_valid (chunk_valid),
    .chunk_ack   (chunk_ack),
    .base        (base),
    .base_valid  (base_valid),
`ifdef SAMPLE_FETCHER_LOOP_EN
    .loop        (loop),
`endif
    .base_ack    (base_ack)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [AW-1:0] q_req[$];
  chk_t        q_chk[$];

  logic [NCH-1:0] ack_en;
  int          stall_left;
  int          ack_budget;
  bit          stale_req;
  int          n_accept = 0;
  int          last_ack_cyc = -10;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [63:0] mdata(input logic [AW-1:0] a);
    return {24'hC0FFEE, 11'h0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: stalls on request, checks request stream, returns data one cycle after acceptance.
  initial begin
    bit            pending;
    bit            just_acc;
    logic [AW-1:0] paddr;
    logic [AW-1:0] held;
    int            req_len;
    int            stalls;
    pending  = 0;
    just_acc = 0;
    paddr    = '0;
    held     = '0;
    req_len  = 0;
    stalls   = 0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_wait = 1'b0;
    mem_if.mem_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_if.mem_ack  = 1'b0;
        mem_if.mem_wait = 1'b0;
        pending  = 0;
        just_acc = 0;
        req_len  = 0;
        stalls   = 0;
      end else begin
        mem_if.mem_ack = 1'b0;
        if (stale_req) begin
          mem_if.mem_ack  = 1'b1;
          mem_if.mem_data = 64'hDEAD_BEEF_0BAD_F00D;
          stale_req = 0;
        end else if (pending && ack_budget > 0) begin
          mem_if.mem_ack  = 1'b1;
          mem_if.mem_data = mdata(paddr);
          ack_budget--;
          last_ack_cyc = cyc;
          pending = 0;
        end
        if (just_acc) begin
          check("read_en_after_accept", 64'(mem_if.mem_read_en), 64'(0));
          just_acc = 0;
        end
        if (mem_if.mem_read_en) begin
          req_len++;
          if (req_len == 1) held = mem_if.mem_addr;
          else check("stall_addr_stable", 64'(mem_if.mem_addr), 64'(held));
          if (stall_left > 0) begin
            mem_if.mem_wait = 1'b1;
            stall_left--;
            stalls++;
          end else begin
            mem_if.mem_wait = 1'b0;
            check("req_len", 64'(req_len), 64'(stalls + 1));
            check("req_expected", 64'(q_req.size() > 0), 64'(1));
            if (q_req.size() > 0) check("req_addr", 64'(mem_if.mem_addr), 64'(q_req.pop_front()));
            pending  = 1;
            paddr    = mem_if.mem_addr;
            just_acc = 1;
            req_len  = 0;
            stalls   = 0;
            n_accept++;
          end
        end else begin
          mem_if.mem_wait = 1'b0;
        end
      end
    end
  end

  // Consumer: acks present chunks on enabled channels.
  initial begin
    chunk_ack = '0;
    forever begin
      @(negedge clk);
      chunk_ack = rst ? '0 : (chunk_valid & ack_en);
    end
  end

  // Chunk monitor: every rising chunk_valid must match the next expected chunk.
  initial begin
    logic [NCH-1:0] prev_cv;
    chk_t e;
    prev_cv = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cv = '0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (chunk_valid[i] && !prev_cv[i]) begin
            check("chunk_expected", 64'(q_chk.size() > 0), 64'(1));
            if (q_chk.size() > 0) begin
              e = q_chk.pop_front();
              check("chunk_ch", 64'(i), 64'(e.ch));
              check("chunk_data", chunk[i*DW +: DW], e.data);
            end
          end
        end
        prev_cv = chunk_valid;
      end
    end
  end

  task automatic push_req(input int ch, input logic [AW-1:0] a);
    chk_t e;
    q_req.push_back(a);
    e.ch   = ch;
    e.data = mdata(a);
    q_chk.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check("rst_read_en", 64'(mem_if.mem_read_en), 64'(0));
    check("rst_mem_addr", 64'(mem_if.mem_addr), 64'(0));
    check("rst_chunk_nonzero", 64'(chunk != '0), 64'(0));
    check("rst_chunk_valid", 64'(chunk_valid), 64'(0));
    check("rst_base_ack", 64'(base_ack), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    base_valid = '0;
    ack_en     = '1;
    stall_left = 0;
    ack_budget = 1000000;
    stale_req  = 0;
    q_req.delete();
    q_chk.delete();
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q_req.size() != 0 || q_chk.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queues_empty", 64'(q_req.size() + q_chk.size()), 64'(0));
    repeat (10) @(negedge clk);
    check("idle_read_en", 64'(mem_if.mem_read_en), 64'(0));
  endtask

  task automatic offer(input logic [NCH-1:0] mask, input logic [NCH-1:0] exp_ack);
    @(negedge clk);
    base_valid = mask;
    #1;
    check("base_ack_zero_latency", 64'(base_ack), 64'(exp_ack));
    @(negedge clk);
    base_valid = '0;
  endtask

  task automatic wait_accepts(input int target);
    int t = 0;
    while (n_accept < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("accept_reached", 64'(n_accept >= target), 64'(1));
  endtask

  // Single stream with a 5-cycle stall on its eleventh request.
  task automatic test_single();
    int start;
    do_reset();
    for (int k = 0; k < 64; k++) push_req(0, AW'(32'h100 + k));
    base[0*AW +: AW] = AW'(32'h100);
    start = n_accept;
    offer(4'b0001, 4'b0001);
    wait_accepts(start + 10);
    stall_left = 5;
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 64; k++)
      for (int c = 0; c < NCH; c++) push_req(c, AW'(32'h1000 * c + k));
    for (int c = 0; c < NCH; c++) base[c*AW +: AW] = AW'(32'h1000 * c);
    offer(4'b1111, 4'b1111);
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_en = 4'b1101;
    for (int c = 0; c < NCH; c++) push_req(c, AW'(32'h1000 * c));
    for (int k = 1; k < 64; k++) begin
      push_req(0, AW'(32'h0000 + k));
      push_req(2, AW'(32'h2000 + k));
      push_req(3, AW'(32'h3000 + k));
    end
    for (int c = 0; c < NCH; c++) base[c*AW +: AW] = AW'(32'h1000 * c);
    offer(4'b1111, 4'b1111);
    drain();
    check("bp_ch1_valid_held", 64'(chunk_valid[1]), 64'(1));
    check("bp_ch1_data", chunk[1*DW +: DW], mdata(AW'(32'h1000)));
  endtask

  task automatic test_rebase_reset();
    int start;
    int t;
    bit found;
    do_reset();
    ack_budget = 64;
    for (int k = 0; k < 64; k++) push_req(0, AW'(32'h200 + k));
    q_req.push_back(AW'(32'h300));
    start = n_accept;
    @(negedge clk);
    base[0*AW +: AW] = AW'(32'h200);
    base_valid = 4'b0001;
    #1;
    check("rebase_first_ack", 64'(base_ack[0]), 64'(1));
    @(negedge clk);
    base[0*AW +: AW] = AW'(32'h300);
    found = 0;
    t = 0;
    while (!found && t < 2000) begin
      @(negedge clk);
      t++;
      if (base_ack[0]) found = 1;
    end
    check("rebase_ack_seen", 64'(found), 64'(1));
    check("rebase_ack_cycle", 64'(cyc), 64'(last_ack_cyc + 1));
    @(negedge clk);
    base_valid = '0;
    wait_accepts(start + 65);
    check("rebase_queue_empty", 64'(q_req.size() + q_chk.size()), 64'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    base_valid = 4'b0010;
    #1;
    check_reset_outputs();
    base_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    stale_req = 1;
    repeat (5) @(negedge clk);
    check("stale_ack_no_valid", 64'(chunk_valid), 64'(0));
    check("stale_ack_no_read", 64'(mem_if.mem_read_en), 64'(0));
  endtask

`ifdef SAMPLE_FETCHER_LOOP_EN
  task automatic test_loop();
    int start;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 64; k++) push_req(0, AW'(32'h40 + k));
    loop = 4'b0001;
    base[0*AW +: AW] = AW'(32'h40);
    start = n_accept;
    offer(4'b0001, 4'b0001);
    wait_accepts(start + 74);
    loop = '0;
    drain();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    base       = '0;
    base_valid = '0;
    ack_en     = '1;
    stall_left = 0;
    ack_budget = 1000000;
    stale_req  = 0;
`ifdef SAMPLE_FETCHER_LOOP_EN
    loop       = '0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    test_single();
    test_round_robin();
    test_backpressure();
    test_rebase_reset();
`ifdef SAMPLE_FETCHER_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
